// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register, next-PC select, IF/ID pipeline register
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc_plus4;
  logic        r_id_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Only the selected source reaches the PC, so unknown redirect inputs stay out when pc_src=00.
  always_comb begin
    w_target = w_pc_plus4;
    case (pc_src)
      2'b00:   w_target = w_pc_plus4;
      2'b01:   w_target = branch_target;
      2'b10:   w_target = jump_target;
      2'b11:   w_target = jr_target;
      default: w_target = w_pc_plus4;
    endcase
  end

  assign w_next_pc = {w_target[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (!stall) begin
      r_pc <= w_next_pc;
    end
  end

  // Flush outranks stall here so a squash during a stall still leaves a bubble for decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_instr    <= NOP_INSTR;
      r_id_pc_plus4 <= 32'd0;
      r_id_valid    <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (flush) begin
      r_id_instr    <= NOP_INSTR;
      r_id_pc_plus4 <= 32'd0;
      r_id_valid    <= 1'b0;
    end else if (!stall) begin
      r_id_instr    <= imem_data;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_valid    <= 1'b1;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign id_instr    = r_id_instr;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign id_valid    = r_id_valid;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [31:0] fetch_count;

  logic        reset2;
  logic [31:0] imem_addr2;
  logic [31:0] pc2;
  logic [31:0] id_instr2;
  logic [31:0] id_pc_plus4_2;
  logic        id_valid2;
  logic [31:0] fetch_count2;

  logic [31:0] mem [0:7];
  int n_checks;
  int n_errors;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_src(pc_src),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .fetch_count(fetch_count)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) u_dut_wrap (
    .clk(clk), .reset(reset2), .stall(1'b0), .flush(1'b0), .pc_src(2'b00),
    .branch_target(32'h0), .jump_target(32'h0), .jr_target(32'h0),
    .imem_addr(imem_addr2), .imem_data(32'h1234_5678), .pc(pc2), .id_instr(id_instr2),
    .id_pc_plus4(id_pc_plus4_2), .id_valid(id_valid2), .fetch_count(fetch_count2)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr[31:5] == 27'd0) imem_data = mem[imem_addr[4:2]];
    else                          imem_data = 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mem[0] = 32'h2008000A; mem[1] = 32'h20090008; mem[2] = 32'h01095025;
    mem[3] = 32'h20090001; mem[4] = 32'h01084020; mem[5] = 32'h010A5825;
    mem[6] = 32'h0;        mem[7] = 32'h0;
    clk = 0; reset = 1; reset2 = 1; stall = 0; flush = 0; pc_src = 2'b00;
    branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;

    #13;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pp4", id_pc_plus4, 32'h0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_wrap_pc", pc2, 32'hFFFF_FFFC);
    check("rst_wrap_addr", imem_addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    reset = 0;

    step();
    check("e1_pc", pc, 32'h4);
    check("e1_addr", imem_addr, 32'h4);
    check("e1_instr", id_instr, 32'h2008000A);
    check("e1_pp4", id_pc_plus4, 32'h4);
    check("e1_valid", {31'd0, id_valid}, 32'd1);
    step();
    check("e2_pc", pc, 32'h8);
    step();
    check("e3_pc", pc, 32'hC);
    check("e3_instr", id_instr, 32'h01095025);
    check("e3_count", fetch_count, 32'd3);

    stall = 1; pc_src = 2'b01; branch_target = 32'h100;
    step();
    check("stall_pc", pc, 32'hC);
    check("stall_instr", id_instr, 32'h01095025);
    check("stall_count", fetch_count, 32'd3);
    stall = 0; pc_src = 2'b00;
    step();
    check("free_instr", id_instr, 32'h20090001);
    check("free_pc", pc, 32'h10);

    pc_src = 2'b01; branch_target = 32'h14; flush = 1;
    step();
    check("br_pc", pc, 32'h14);
    check("br_instr", id_instr, 32'h0);
    check("br_valid", {31'd0, id_valid}, 32'd0);
    check("br_pp4", id_pc_plus4, 32'h0);
    check("br_count", fetch_count, 32'd4);
    pc_src = 2'b00; flush = 0;
    step();
    check("after_br_instr", id_instr, 32'h010A5825);
    check("after_br_pp4", id_pc_plus4, 32'h18);
    check("after_br_count", fetch_count, 32'd5);

    pc_src = 2'b10; jump_target = 32'h0000_000B;
    step();
    check("j_pc", pc, 32'h8);
    pc_src = 2'b00;
    step();
    check("j_instr", id_instr, 32'h01095025);
    check("j_next_pc", pc, 32'hC);
    pc_src = 2'b11; jr_target = 32'h4;
    step();
    check("jr_pc", pc, 32'h4);
    check("jr_count", fetch_count, 32'd8);
    pc_src = 2'b00;
    step();
    check("pre_sf_pc", pc, 32'h8);

    stall = 1; flush = 1; pc_src = 2'b01; branch_target = 32'h40;
    step();
    check("sf_pc", pc, 32'h8);
    check("sf_valid", {31'd0, id_valid}, 32'd0);
    check("sf_instr", id_instr, 32'h0);
    check("sf_count", fetch_count, 32'd9);
    stall = 0; flush = 0; pc_src = 2'b00;

    step();
    step();
    check("pre_rst_pc", pc, 32'h10);
    check("pre_rst_count", fetch_count, 32'd11);
    #2;
    reset = 1;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_valid", {31'd0, id_valid}, 32'd0);
    check("async_rst_count", fetch_count, 32'd0);
    @(negedge clk);
    reset = 0;

    reset2 = 0;
    step();
    check("wrap_pc", pc2, 32'h0);
    check("wrap_pp4", id_pc_plus4_2, 32'h0);
    check("wrap_instr", id_instr2, 32'h1234_5678);
    check("wrap_count", fetch_count2, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
